// File: rtl/simon_player_input.sv
// Player-side button front end for Simon: synchronises and debounces four buttons,
// turns a clean one-hot press into the playerNum/playerPressed hold and release strobe.
module simon_player_input #(
    parameter int DEBOUNCE = 3,
    parameter int TIMEOUT  = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       simonTurn,
    input  logic       gameOver,
    output logic [1:0] playerNum,
    output logic       playerPressed,
    output logic       pressStrobe,
    output logic       timeout,
    output logic [3:0] led
);

    // state    | meaning
    // IDLE     | not the player's turn, outputs quiet
    // WAIT     | debouncing for a single clean press, idle timer running
    // PRESSED  | press accepted, debouncing the release
    // TIMEDOUT | player took too long, parked until reset
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT     = 2'd1;
    localparam logic [1:0] PRESSED  = 2'd2;
    localparam logic [1:0] TIMEDOUT = 2'd3;

    localparam logic [3:0] DEB_CNT    = 4'(DEBOUNCE);
    localparam logic [8:0] TOUT_CNT   = 9'(TIMEOUT);
    localparam bit         TIMEOUT_ON = (TIMEOUT > 0);

    logic [1:0] state;
    logic [3:0] btnMeta;
    logic [3:0] btnSync;
    logic [3:0] candidate;
    logic [3:0] stableCnt;
    logic [3:0] releaseCnt;
    logic [8:0] idleCnt;

    logic       enable;
    logic       bsOneHot;
    logic [3:0] stableNext;
    logic [3:0] releaseNext;
    logic [8:0] idleNext;
    logic       pressHit;
    logic       releaseHit;
    logic       timeoutHit;

    function automatic logic [1:0] encode(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        if (v[3])      idx = 2'd3;
        else if (v[2]) idx = 2'd2;
        else if (v[1]) idx = 2'd1;
        return idx;
    endfunction

    always_comb begin
        enable   = !simonTurn && !gameOver;
        bsOneHot = $onehot(btnSync);

        // Any change or non-one-hot pattern restarts the stability count.
        if (bsOneHot && (btnSync == candidate))
            stableNext = (stableCnt == 4'hF) ? stableCnt : stableCnt + 4'd1;
        else
            stableNext = bsOneHot ? 4'd1 : 4'd0;

        releaseNext = (releaseCnt == 4'hF) ? releaseCnt : releaseCnt + 4'd1;
        idleNext    = (idleCnt == 9'h1FF) ? idleCnt : idleCnt + 9'd1;

        pressHit   = bsOneHot && (stableNext >= DEB_CNT);
        releaseHit = (btnSync == 4'd0) && (releaseNext >= DEB_CNT);
        timeoutHit = TIMEOUT_ON && (idleNext >= TOUT_CNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            btnMeta       <= 4'd0;
            btnSync       <= 4'd0;
            candidate     <= 4'd0;
            stableCnt     <= 4'd0;
            releaseCnt    <= 4'd0;
            idleCnt       <= 9'd0;
            playerNum     <= 2'd0;
            playerPressed <= 1'b0;
            pressStrobe   <= 1'b0;
            timeout       <= 1'b0;
            led           <= 4'd0;
        end else begin
            btnMeta     <= btn;
            btnSync     <= btnMeta;
            pressStrobe <= 1'b0;

            case (state)
                IDLE: begin
                    playerNum     <= 2'd0;
                    playerPressed <= 1'b0;
                    led           <= 4'd0;
                    if (enable) begin
                        state     <= WAIT;
                        idleCnt   <= 9'd0;
                        stableCnt <= 4'd0;
                        candidate <= 4'd0;
                    end
                end

                WAIT: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else begin
                        idleCnt   <= idleNext;
                        candidate <= btnSync;
                        stableCnt <= stableNext;
                        // A press landing on the timeout edge takes priority.
                        if (pressHit) begin
                            playerNum     <= encode(btnSync);
                            playerPressed <= 1'b1;
                            led           <= btnSync;
                            releaseCnt    <= 4'd0;
                            state         <= PRESSED;
                        end else if (timeoutHit) begin
                            timeout <= 1'b1;
                            state   <= TIMEDOUT;
                        end
                    end
                end

                PRESSED: begin
                    if (!enable) begin
                        playerNum     <= 2'd0;
                        playerPressed <= 1'b0;
                        led           <= 4'd0;
                        state         <= IDLE;
                    end else if (btnSync != 4'd0) begin
                        releaseCnt <= 4'd0;
                    end else begin
                        releaseCnt <= releaseNext;
                        if (releaseHit) begin
                            playerNum     <= 2'd0;
                            playerPressed <= 1'b0;
                            led           <= 4'd0;
                            pressStrobe   <= 1'b1;
                            idleCnt       <= 9'd0;
                            stableCnt     <= 4'd0;
                            candidate     <= 4'd0;
                            state         <= WAIT;
                        end
                    end
                end

                TIMEDOUT: begin
                    playerNum     <= 2'd0;
                    playerPressed <= 1'b0;
                    led           <= 4'd0;
                    timeout       <= 1'b1;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
